// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// Used by reg_file_sb and reg_scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    function automatic int aw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Write-pending bits: one per register, reserve beats release,
// bit 0 is hard-wired clear; two combinational lookup ports.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = aw_of(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_idx,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_idx,
    input  logic [AW-1:0] i_rs1,
    input  logic [AW-1:0] i_rs2,
    output logic          o_busy1,
    output logic          o_busy2
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_next;

    always_comb begin
        w_next = r_busy;
        if (i_clr_en) w_next[i_clr_idx] = 1'b0;
        if (i_set_en) w_next[i_set_idx] = 1'b1;
        w_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_next;
    end

    assign o_busy1 = (i_rs1 != '0) && r_busy[i_rs1];
    assign o_busy2 = (i_rs2 != '0) && r_busy[i_rs2];

endmodule

// File: rtl/reg_file_sb.sv
// Register file with post-reset sequential clear and hazard scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback to the reads.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    localparam int AW   = aw_of(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            reg_write_en,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] rd_value,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_value,
    output logic [XLEN-1:0] rs2_value,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            ready
);

    state_e          r_state;
    logic [AW-1:0]   r_clr_idx;
    logic [XLEN-1:0] r_mem [NREGS];

    logic            w_run;
    logic            w_wr;
    logic            w_rsv;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [XLEN-1:0] w_wdata;

    logic [AW-1:0]   w_rs      [2];
    logic            w_sb_busy [2];
    logic [XLEN-1:0] w_val     [2];
    logic            w_busy    [2];

    assign w_run = (r_state == RUN);
    assign w_wr  = w_run && reg_write_en && (rd != '0);
    assign w_rsv = w_run && rsv_en && (rsv_rd != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_idx <= AW'(1);
        end else if (r_state == CLEAR) begin
            if (r_clr_idx == AW'(NREGS - 1)) r_state <= RUN;
            r_clr_idx <= r_clr_idx + AW'(1);
        end
    end

    // No reset on the array itself so it can map onto RAM.
    assign w_we    = rst_n && (!w_run || w_wr);
    assign w_waddr = w_run ? rd : r_clr_idx;
    assign w_wdata = w_run ? rd_value : '0;

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_set_en  (w_rsv),
        .i_set_idx (rsv_rd),
        .i_clr_en  (w_wr),
        .i_clr_idx (rd),
        .i_rs1     (rs1),
        .i_rs2     (rs2),
        .o_busy1   (w_sb_busy[0]),
        .o_busy2   (w_sb_busy[1])
    );

    assign w_rs[0] = rs1;
    assign w_rs[1] = rs2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_val[p]  = r_mem[w_rs[p]];
            w_busy[p] = w_sb_busy[p];
`ifdef REGFILE_BYPASS_EN
            if (w_wr && (rd == w_rs[p])) begin
                w_val[p] = rd_value;
                // A new producer reserving this register keeps it busy.
                if (!(rsv_en && (rsv_rd == w_rs[p]))) w_busy[p] = 1'b0;
            end
`endif
            if (!w_run || (w_rs[p] == '0)) begin
                w_val[p]  = '0;
                w_busy[p] = 1'b0;
            end
        end
    end

    assign rs1_value = w_val[0];
    assign rs2_value = w_val[1];
    assign rs1_busy  = w_busy[0];
    assign rs2_busy  = w_busy[1];
    assign ready     = w_run;

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the core's 8-entry register file. It has configurable data width and register count, and a write-pending scoreboard for pipeline hazard detection. After reset, a sequential clear walks every register to zero, so the array maps to RAM without a per-entry reset. Optional write-to-read bypass is available. Sits between decode (reads, reservations) and writeback (writes) in the RISC-V datapath.

## Interface
- XLEN, 32, data width of every register
- NREGS, 32, register count; power of two, ≥ 4; AW = log2(NREGS)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- reg_write_en  input  1  writeback strobe
- rd  input  AW  writeback register index
- rd_value  input  XLEN  writeback data
- rsv_en  input  1  reserve (mark pending) strobe from issue
- rsv_rd  input  AW  register index to reserve
- rs1, rs2  input  AW  read indices
- rs1_value, rs2_value  output  XLEN  read data (combinational)
- rs1_busy, rs2_busy  output  1  read register has pending write (combinational)
- ready  output  1  clear finished; block accepts traffic

## Operation
- FSM states: CLEAR, RUN.
- Reset (rst_n=0 at an edge) produces the following state:
  - state=CLEAR, clr_idx=1, all scoreboard bits 0, ready=0.
  - Applies from any state, including mid-CLEAR; the clear restarts at index 1.
- CLEAR behaviour:
  - Each cycle writes 0 to reg[clr_idx], then clr_idx+1.
  - When clr_idx==NREGS-1, that write completes and the state goes to RUN.
  - reg_write_en and rsv_en are ignored; outputs are zeros, busy 0.
- RUN, write:
  - reg_write_en && rd!=0 writes rd_value to reg[rd] at the edge.
  - It clears busy[rd] at the same edge.
- RUN, reserve:
  - rsv_en && rsv_rd!=0 sets busy[rsv_rd] at the edge.
  - Simultaneous write and reserve of the same index: reserve wins (new producer), data is still written, busy stays 1.
- x0 behaviour:
  - Index 0 is never written, never cleared by the FSM, and never reserved.
  - Reads of index 0 return 0 with busy=0 regardless of array contents.
- Reads are combinational from the array (plus bypass, see Configuration).
  - Values are read regardless of the busy bit; the consumer decides whether to stall.
- Writing a non-reserved register is legal and leaves busy at 0.

## Timing
- Reset values: ready=0, rs*_value=0, rs*_busy=0.
- Clear latency: ready rises NREGS-1 cycles after the first edge with rst_n=1.
- Write latency: the value is visible on reads the cycle after the write edge (same cycle with bypass).
- Reserve latency: rs*_busy=1 from the cycle after the reserve edge.
- Release latency: busy falls the cycle after the write edge (same cycle with bypass).
- No backpressure: writes and reservations are single-cycle strobes, always accepted in RUN.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If reg_write_en && rd!=0 && rd==rsN in RUN, rsN_value=rd_value and rsN_busy=0 in that same cycle.
  - Exception: if rsv_en also targets rsN that cycle, rsN_busy stays as the registered bit (no forward release).
- REGFILE_BYPASS_EN undefined:
  - Reads return the stored value and the registered busy bit only.
  - The pipeline must allow one extra cycle for read-after-write.

## Structure
- Shared package regfile_pkg holds:
  - FSM state enum (CLEAR, RUN)
  - default XLEN and NREGS constants
  - clog2-based AW helper
- One sub-module: reg_scoreboard (NREGS busy bits with set/clear/priority and two combinational lookup ports).
- Array, clear FSM and bypass muxing stay in the top module.

## Test plan
- Reset, NREGS=32: hold rst_n=0 2 cycles, release, then read all 31 non-zero indices.
  - ready=0 for 31 cycles, then 1.
  - Every read returns 0 with busy 0.
- Write x5=0xDEADBEEF, then read rs1=5:
  - Next cycle returns 0xDEADBEEF.
  - With REGFILE_BYPASS_EN, the same cycle returns it.
- Write x0=0x1234 and reserve x0:
  - rs1=0 reads 0, busy 0, always.
- Reserve x7, hold 3 cycles, then write x7=0x55:
  - busy=1 for 3 cycles.
  - busy falls after the write, and value=0x55.
- Same-cycle write x9=0xA and reserve x9:
  - Data reads 0xA.
  - busy=1 remains until a later write.
- Mid-clear reset: deassert rst_n, pull it low after 10 cycles, release.
  - ready rises exactly 31 cycles after the second release.
  - Writes issued during CLEAR have no effect.
